// File: rtl/cle_key_reader_if.sv
`default_nettype none
// ============================================================================
//  Module   : cle_key_reader_if
//  Purpose  : Bundles the command/result handshake of the CLE2ac key reader
//             with the serial strobes that run to the key PAL.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Signals
//    start       host -> reader   one-cycle request to read one word
//    cmd[3:0]    host -> reader   address nibble for bit 0 of the word
//    busy        reader -> host   high from accepted start until hand-off
//    dout        reader -> host   assembled word, LSB = first bit read
//    dout_valid  reader -> host   word available
//    dout_ready  host -> reader   consumer accepts word
//    key_sser_n  reader -> key    select, active low
//    key_ba13    reader -> key    address bit 13
//    key_ba12    reader -> key    address bit 12
//    key_ba[3:0] reader -> key    BA7..BA4
//    key_br_w    reader -> key    read/write, 1 = read
//    key_clk     reader -> key    key register clock
//    key_sdrd    key -> reader    serial read data (externally pulled)
//  Modports
//    slave  : the reader itself
//    master : the surrounding system (bus controller plus key)
// ============================================================================
interface cle_key_reader_if #(
  parameter int BITS = 8
);
  logic            start;
  logic [3:0]      cmd;
  logic            busy;
  logic [BITS-1:0] dout;
  logic            dout_valid;
  logic            dout_ready;
  logic            key_sser_n;
  logic            key_ba13;
  logic            key_ba12;
  logic [3:0]      key_ba;
  logic            key_br_w;
  logic            key_clk;
  logic            key_sdrd;

  modport slave (
    input  start, cmd, dout_ready, key_sdrd,
    output busy, dout, dout_valid,
           key_sser_n, key_ba13, key_ba12, key_ba, key_br_w, key_clk
  );

  modport master (
    output start, cmd, dout_ready, key_sdrd,
    input  busy, dout, dout_valid,
           key_sser_n, key_ba13, key_ba12, key_ba, key_br_w, key_clk
  );
endinterface

`default_nettype wire

// File: rtl/cle_key_reader.sv
`default_nettype none
// ============================================================================
//  Module   : cle_key_reader
//  Purpose  : Host-side sequencer for the CLE2ac serial key. For every
//             requested word it walks BITS bit slots, each made of
//             SETUP -> SAMPLE -> HIGH -> GAP, strobing the key's select,
//             address, read and clock lines, capturing SDRD LSB first, and
//             finally presenting the word on a valid/ready output.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk   in   system clock
//    rst   in   asynchronous active-high reset
//    bus   slave modport of cle_key_reader_if (command, result, key strobes)
//  Parameters
//    BITS       bits per word (2..16)
//    SETUP_LEN  cycles selects settle with key_clk low before sampling (>=1)
//    HIGH_LEN   cycles key_clk is held high (>=1)
//    GAP_LEN    cycles deselected between bits (>=1)
//  Build option
//    CLE_SAMPLE_MAJORITY_EN  when defined, SAMPLE lasts three cycles and the
//                            stored bit is the majority of the three reads.
// ============================================================================
module cle_key_reader #(
  parameter int BITS      = 8,
  parameter int SETUP_LEN = 2,
  parameter int HIGH_LEN  = 2,
  parameter int GAP_LEN   = 1
) (
  input  logic             clk,
  input  logic             rst,
  cle_key_reader_if.slave  bus
);

`ifdef CLE_SAMPLE_MAJORITY_EN
  localparam int SAMPLE_LEN = 3;
`else
  localparam int SAMPLE_LEN = 1;
`endif

  // One phase counter serves every timed state, so it is sized for the
  // longest of them.
  localparam int PH_MAX0 = (SETUP_LEN > HIGH_LEN) ? SETUP_LEN : HIGH_LEN;
  localparam int PH_MAX1 = (PH_MAX0 > GAP_LEN) ? PH_MAX0 : GAP_LEN;
  localparam int PH_MAX  = (PH_MAX1 > SAMPLE_LEN) ? PH_MAX1 : SAMPLE_LEN;
  localparam int PH_W    = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;
  localparam int BC_W    = $clog2(BITS);

  localparam logic [PH_W-1:0] SETUP_LAST  = PH_W'(SETUP_LEN - 1);
  localparam logic [PH_W-1:0] SAMPLE_LAST = PH_W'(SAMPLE_LEN - 1);
  localparam logic [PH_W-1:0] HIGH_LAST   = PH_W'(HIGH_LEN - 1);
  localparam logic [PH_W-1:0] GAP_LAST    = PH_W'(GAP_LEN - 1);
  localparam logic [BC_W-1:0] LAST_BIT    = BC_W'(BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SETUP  = 3'd1,
    S_SAMPLE = 3'd2,
    S_HIGH   = 3'd3,
    S_GAP    = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  state_t          state_q;
  logic [PH_W-1:0] phase_q;
  logic [BC_W-1:0] bit_cnt_q;
  logic [3:0]      cmd_q;
  logic [BITS-1:0] shift_q;
  logic            busy_q;
  logic            dout_valid_q;
  logic            sser_n_q;
  logic            ba13_q;
  logic            ba12_q;
  logic [3:0]      ba_q;
  logic            br_w_q;
  logic            key_clk_q;

  // Value that gets written into the shift register at the end of SAMPLE.
  logic            bit_d;

`ifdef CLE_SAMPLE_MAJORITY_EN
  // First two reads of the slot; the third is taken straight from the pin.
  logic [1:0]      samp_q;
  assign bit_d = (samp_q[0] & samp_q[1]) |
                 (samp_q[0] & bus.key_sdrd) |
                 (samp_q[1] & bus.key_sdrd);
`else
  assign bit_d = bus.key_sdrd;
`endif

  // All key strobes are registered and only updated on state entry, so the
  // select lines can never move while key_clk is high: HIGH is entered with
  // selects already stable, and deselect happens on the same edge that
  // drops key_clk (the key only acts on the rising edge).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      phase_q      <= '0;
      bit_cnt_q    <= '0;
      cmd_q        <= 4'h0;
      shift_q      <= '0;
      busy_q       <= 1'b0;
      dout_valid_q <= 1'b0;
      sser_n_q     <= 1'b1;
      ba13_q       <= 1'b1;
      ba12_q       <= 1'b0;
      ba_q         <= 4'h0;
      br_w_q       <= 1'b0;
      key_clk_q    <= 1'b0;
`ifdef CLE_SAMPLE_MAJORITY_EN
      samp_q       <= 2'b00;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            cmd_q     <= bus.cmd;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            phase_q   <= '0;
            busy_q    <= 1'b1;
            // Select the key for bit 0; the command nibble only addresses
            // the first bit of the word.
            sser_n_q  <= 1'b0;
            ba13_q    <= 1'b0;
            ba12_q    <= 1'b1;
            br_w_q    <= 1'b1;
            key_clk_q <= 1'b0;
            ba_q      <= bus.cmd;
            state_q   <= S_SETUP;
          end
        end

        S_SETUP: begin
          if (phase_q == SETUP_LAST) begin
            phase_q <= '0;
            state_q <= S_SAMPLE;
          end else begin
            phase_q <= phase_q + 1'b1;
          end
        end

        S_SAMPLE: begin
          if (phase_q == SAMPLE_LAST) begin
            shift_q[bit_cnt_q] <= bit_d;
            key_clk_q          <= 1'b1;
            phase_q            <= '0;
            state_q            <= S_HIGH;
          end else begin
`ifdef CLE_SAMPLE_MAJORITY_EN
            samp_q[phase_q[0]] <= bus.key_sdrd;
`endif
            phase_q <= phase_q + 1'b1;
          end
        end

        S_HIGH: begin
          if (phase_q == HIGH_LAST) begin
            key_clk_q <= 1'b0;
            sser_n_q  <= 1'b1;
            ba13_q    <= 1'b1;
            ba12_q    <= 1'b0;
            br_w_q    <= 1'b0;
            ba_q      <= 4'h0;
            phase_q   <= '0;
            state_q   <= S_GAP;
          end else begin
            phase_q <= phase_q + 1'b1;
          end
        end

        S_GAP: begin
          if (phase_q == GAP_LAST) begin
            phase_q <= '0;
            if (bit_cnt_q == LAST_BIT) begin
              dout_valid_q <= 1'b1;
              state_q      <= S_DONE;
            end else begin
              bit_cnt_q <= bit_cnt_q + 1'b1;
              sser_n_q  <= 1'b0;
              ba13_q    <= 1'b0;
              ba12_q    <= 1'b1;
              br_w_q    <= 1'b1;
              ba_q      <= 4'h0;
              state_q   <= S_SETUP;
            end
          end else begin
            phase_q <= phase_q + 1'b1;
          end
        end

        S_DONE: begin
          if (bus.dout_ready) begin
            dout_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            state_q      <= S_IDLE;
          end
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.busy       = busy_q;
  assign bus.dout       = shift_q;
  assign bus.dout_valid = dout_valid_q;
  assign bus.key_sser_n = sser_n_q;
  assign bus.key_ba13   = ba13_q;
  assign bus.key_ba12   = ba12_q;
  assign bus.key_ba     = ba_q;
  assign bus.key_br_w   = br_w_q;
  assign bus.key_clk    = key_clk_q;

  // cmd_q holds the accepted nibble for the life of the word; it is kept so
  // the command that produced a word can be observed while the word is
  // in flight.
  logic unused_cmd;
  assign unused_cmd = ^cmd_q;

endmodule

`default_nettype wire

// File: tb/tb_cle_key_reader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cle_key_reader
//  Purpose  : Self-checking bench for cle_key_reader. A behavioural key model
//             serves random words bit by bit (advancing on each key_clk rise),
//             the stimulus pushes the expected word and accept time into a
//             scoreboard, and a separate monitor pops and compares whenever
//             the reader presents dout_valid. A protocol monitor watches the
//             key strobes every cycle.
//  Revision : 1.0  initial release
//  Build option: CLE_SAMPLE_MAJORITY_EN (adds a one-cycle SDRD glitch on the
//             middle read of bit 3, which majority sampling must reject).
// ============================================================================
module tb_cle_key_reader;
  localparam int BITS      = 8;
  localparam int SETUP_LEN = 2;
  localparam int HIGH_LEN  = 2;
  localparam int GAP_LEN   = 1;
`ifdef CLE_SAMPLE_MAJORITY_EN
  localparam int SAMP = 3;
`else
  localparam int SAMP = 1;
`endif
  // Clock edges from the accepting edge (counted as 1) to dout_valid.
  localparam int LAT = 1 + BITS * (SETUP_LEN + SAMP + HIGH_LEN + GAP_LEN);

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cle_key_reader_if #(.BITS(BITS)) bus ();

  cle_key_reader #(
    .BITS(BITS), .SETUP_LEN(SETUP_LEN), .HIGH_LEN(HIGH_LEN), .GAP_LEN(GAP_LEN)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  typedef struct {
    logic [BITS-1:0] word;
    logic [3:0]      cmd;
    longint          ta;
  } exp_t;
  exp_t sb[$];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] outs();
    return 32'({bus.busy, bus.dout_valid, bus.key_sser_n, bus.key_ba13, bus.key_ba12,
                bus.key_ba, bus.key_br_w, bus.key_clk, bus.dout});
  endfunction
  localparam logic [31:0] RST_VEC =
    32'({1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, {BITS{1'b0}}});

  // ---------------- key model + protocol monitor ----------------
  logic [BITS-1:0] key_word = '0;
  logic [3:0]      key_cmd  = 4'h0;
  logic       p_clk = 1'b0, p_sser = 1'b1, p_brw = 1'b0, p_busy = 1'b0;
  logic [3:0] p_ba = 4'h0;
  int kidx = 0, sel_cnt = 0, clk_pulses = 0, gcnt = -1;

  always @(negedge clk) begin
    if (rst) begin
      bus.key_sdrd = 1'b0;
      gcnt = -1;
    end else begin
      if (bus.busy && !p_busy) begin
        kidx = 0; sel_cnt = 0; clk_pulses = 0;
        bus.key_sdrd = key_word[0];
      end
      if (!bus.key_sser_n && p_sser) begin
        sel_cnt++;
        gcnt = 0;
      end else if (gcnt >= 0) begin
        gcnt++;
`ifdef CLE_SAMPLE_MAJORITY_EN
        if (sel_cnt == 4 && gcnt == SETUP_LEN + 1) bus.key_sdrd = ~key_word[3];
        if (sel_cnt == 4 && gcnt == SETUP_LEN + 2) bus.key_sdrd = key_word[3];
`endif
      end
      if (bus.key_clk && !p_clk) begin
        clk_pulses++;
        kidx++;
        bus.key_sdrd = (kidx < BITS) ? key_word[kidx] : 1'b0;
        gcnt = -1;
      end
      if (bus.key_clk !== p_clk) begin
        if (bus.key_clk) chk("clk_rise_selected", 32'({p_sser, bus.key_sser_n}), 32'd0);
        // The key registers on the rising edge only; the fall shares its
        // edge with the deselect, so only "selected while high" is required.
        else chk("clk_fall_selected", 32'(p_sser), 32'd0);
      end else if (bus.key_clk) begin
        chk("sel_stable_high", 32'({bus.key_ba, bus.key_sser_n, bus.key_br_w}),
            32'({p_ba, p_sser, p_brw}));
      end
      chk("key_ba", 32'(bus.key_ba),
          32'((!bus.key_sser_n && sel_cnt == 1) ? key_cmd : 4'h0));
    end
    p_clk = bus.key_clk; p_sser = bus.key_sser_n; p_brw = bus.key_br_w;
    p_ba = bus.key_ba; p_busy = bus.busy;
  end

  // ---------------- scoreboard monitor ----------------
  logic seen = 1'b0;
  logic hs_prev = 1'b0;
  logic [BITS-1:0] held = '0;

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      seen = 1'b0; hs_prev = 1'b0;
    end else begin
      if (hs_prev) begin
        chk("valid_drop", 32'(bus.dout_valid), 32'd0);
        chk("busy_drop", 32'(bus.busy), 32'd0);
        hs_prev = 1'b0;
      end
      if (bus.dout_valid) begin
        if (!seen) begin
          seen = 1'b1;
          held = bus.dout;
          if (sb.size() == 0) begin
            chk("unexpected_word", 32'd1, 32'd0);
          end else begin
            e = sb.pop_front();
            chk("dout", 32'(bus.dout), 32'(e.word));
            chk("latency", 32'(($time - 5 - e.ta) / 10 + 1), 32'(LAT));
            chk("clk_pulses", 32'(clk_pulses), 32'(BITS));
            chk("busy_in_done", 32'(bus.busy), 32'd1);
          end
        end else begin
          chk("dout_stable", 32'(bus.dout), 32'(held));
        end
        if (bus.dout_ready) begin
          seen = 1'b0;
          hs_prev = 1'b1;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Must be called one time unit after a rising edge with busy low.
  task automatic issue(input logic [BITS-1:0] w, input logic [3:0] c);
    exp_t e;
    key_word  = w;
    key_cmd   = c;
    bus.cmd   = c;
    bus.start = 1'b1;
    e.word = w; e.cmd = c; e.ta = longint'($time) + 9;
    sb.push_back(e);
    step();
    bus.start = 1'b0;
  endtask

  // While busy, optionally jitter dout_ready and throw in stray starts; a
  // start seen with busy high can only land outside IDLE, so it must be
  // ignored.
  task automatic wait_idle(input bit rnd);
    int n = 0;
    while (bus.busy && n < 400) begin
      if (rnd) begin
        bus.dout_ready = ($urandom_range(0, 2) != 0);
        if ($urandom_range(0, 9) == 0) begin
          bus.start = 1'b1;
          bus.cmd   = 4'($urandom);
        end
      end
      step();
      bus.start = 1'b0;
      n++;
    end
    if (bus.busy) chk("idle_timeout", 32'd1, 32'd0);
  endtask

  initial begin
    int n;
    rst = 1'b1;
    bus.start = 1'b0;
    bus.cmd = 4'h0;
    bus.dout_ready = 1'b0;
    repeat (3) step();
    chk("reset_values", outs(), RST_VEC);
    rst = 1'b0;

    // Idle with no start: everything stays at reset values.
    for (int i = 0; i < 100; i++) begin
      step();
      chk("idle_outputs", outs(), RST_VEC);
    end

    // Directed word: SDRD 1,0,1,1,0,0,1,0 -> 8'h4D, cmd 4'hA.
    bus.dout_ready = 1'b1;
    issue(8'h4D, 4'hA);
    wait_idle(1'b0);

    // Result held off for 20 cycles with a stray start in the middle.
    bus.dout_ready = 1'b0;
    issue(BITS'($urandom), 4'($urandom));
    n = 0;
    while (!bus.dout_valid && n < 200) begin
      step();
      n++;
    end
    chk("t4_valid_seen", 32'(bus.dout_valid), 32'd1);
    for (int i = 0; i < 20; i++) begin
      if (i == 5) begin
        bus.start = 1'b1;
        bus.cmd   = 4'h5;
      end
      step();
      bus.start = 1'b0;
      chk("t4_busy_held", 32'(bus.busy), 32'd1);
      chk("t4_valid_held", 32'(bus.dout_valid), 32'd1);
    end
    bus.dout_ready = 1'b1;
    step();
    chk("t4_valid_cleared", 32'(bus.dout_valid), 32'd0);
    issue(BITS'($urandom), 4'($urandom));
    wait_idle(1'b0);

    // Reset asserted mid-word, between clock edges.
    issue(BITS'($urandom), 4'($urandom));
    repeat (20) step();
    #2 rst = 1'b1;
    #1 chk("t2_async_reset", outs(), RST_VEC);
    sb.delete();
    step();
    step();
    rst = 1'b0;
    for (int i = 0; i < 60; i++) begin
      step();
      chk("t2_stay_idle", outs(), RST_VEC);
    end

    // Random traffic with jittered dout_ready and stray starts.
    for (int t = 0; t < 25; t++) begin
      issue(BITS'($urandom), 4'($urandom));
      wait_idle(1'b1);
      bus.dout_ready = 1'b1;
      repeat ($urandom_range(0, 3)) step();
    end

    bus.dout_ready = 1'b1;
    wait_idle(1'b0);
    repeat (3) step();
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
